// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order storage of {pc, word} entries for the fetch buffer, with flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  fetch_entry_t             i_entry,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Pointer and occupancy tracking; power-of-two depth makes pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_entry;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch PC, credit-limited imem requests, redirect flush/drain and instruction queue.
// Optional FETCH_BYPASS_EN forwards a response straight to Instr when the queue is empty.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] Instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic         r_run;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] w_drop_next;
  logic [CW-1:0] w_total;
  logic [CW:0]   w_credit_sum;
  logic [31:0]  r_hold_instr;
  logic [31:0]  r_hold_pc;

  logic         w_grant;
  logic         w_drop_rsp;
  logic         w_bypass;
  logic         w_push;
  logic         w_pop;
  fetch_entry_t w_entry;
  fetch_entry_t w_head;
  logic [CW-1:0] w_count;
  logic         w_full;
  logic         w_empty;

  assign w_credit_sum = {1'b0, w_count} + {1'b0, r_outstanding};
  assign imem_req     = r_run & (r_state == FETCH) & (w_credit_sum < (CW+1)'(DEPTH));
  assign imem_addr    = r_fetch_pc;
  assign w_grant      = imem_req & imem_gnt;
  assign w_total      = r_outstanding + CW'(w_grant) - CW'(imem_rvalid);
  assign w_drop_rsp   = imem_rvalid & (redirect | (r_state == DRAIN));

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_empty & (r_state == FETCH) & ~redirect & imem_rvalid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push  = imem_rvalid & ~w_drop_rsp & ~(w_bypass & instr_ready);
  assign w_pop   = ~redirect & instr_ready & ~w_empty;
  assign w_entry = '{pc: r_resp_pc, instr: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Head of queue (or bypassed response); otherwise the last presented word is held.
  always_comb begin
    instr_valid = 1'b0;
    Instr       = r_hold_instr;
    instr_pc    = r_hold_pc;
    if (!w_empty) begin
      instr_valid = 1'b1;
      Instr       = w_head.instr;
      instr_pc    = w_head.pc;
    end else if (w_bypass) begin
      instr_valid = 1'b1;
      Instr       = imem_rdata;
      instr_pc    = r_resp_pc;
    end else begin
      instr_valid = 1'b0;
    end
  end

  // Next state and stale-response count; redirect overrides everything.
  always_comb begin
    w_next_state = r_state;
    w_drop_next  = r_drop;
    if (redirect) begin
      w_drop_next  = w_total;
      w_next_state = (w_total != '0) ? DRAIN : FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          w_next_state = FETCH;
          w_drop_next  = '0;
        end
        DRAIN: begin
          if (imem_rvalid && (r_drop != '0)) w_drop_next = r_drop - CW'(1);
          else                               w_drop_next = r_drop;
          w_next_state = (w_drop_next == '0) ? FETCH : DRAIN;
        end
        default: begin
          w_next_state = FETCH;
          w_drop_next  = '0;
        end
      endcase
    end
  end

  // State register and credit/drop counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= FETCH;
      r_run         <= 1'b0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_state       <= w_next_state;
      r_run         <= 1'b1;
      r_outstanding <= w_total;
      r_drop        <= w_drop_next;
    end
  end

  // Request PC and the PC of the oldest live response; both retarget on redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= word_align(redirect_pc);
      r_resp_pc  <= word_align(redirect_pc);
    end else begin
      if (w_grant)                    r_fetch_pc <= r_fetch_pc + WORD_BYTES;
      if (imem_rvalid && !w_drop_rsp) r_resp_pc  <= r_resp_pc + WORD_BYTES;
    end
  end

  // Capture whatever is presented so an empty queue keeps showing it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold_instr <= 32'h0000_0000;
      r_hold_pc    <= 32'h0000_0000;
    end else if (instr_valid) begin
      r_hold_instr <= Instr;
      r_hold_pc    <= instr_pc;
    end else begin
      r_hold_instr <= r_hold_instr;
      r_hold_pc    <= r_hold_pc;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer against a queue-based model of fetch, memory and core.
module tb_fetch_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instr;
  logic [31:0] instr_pc;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .Instr       (Instr),
    .instr_pc    (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  logic [31:0] buf_pc[$];
  logic [31:0] buf_w[$];
  logic [31:0] infl[$];
  int          n_stale;
  logic [31:0] m_fetch_pc;
  logic [31:0] last_i;
  logic [31:0] last_pc;
  bit          run;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          last_due;
  int          t = 0;

  // stimulus knobs
  int p_gnt, p_ready, p_redir, lat_max, redir_mode;
  bit force_redir = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, t);
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    buf_pc.delete(); buf_w.delete(); infl.delete();
    mq_addr.delete(); mq_due.delete();
    n_stale = 0; m_fetch_pc = 32'h0; last_i = 32'h0; last_pc = 32'h0;
    run = 1'b0; last_due = t;
  endtask

  task automatic check_reset_outputs();
    check_val("rst_req",   {31'h0, imem_req},    32'h0);
    check_val("rst_addr",  imem_addr,            32'h0);
    check_val("rst_valid", {31'h0, instr_valid}, 32'h0);
    check_val("rst_instr", Instr,                32'h0);
    check_val("rst_pc",    instr_pc,             32'h0);
  endtask

  task automatic step();
    logic [31:0] e_i, e_pc, rsp_pc;
    bit e_v, e_req, byp, grant, pop, rv, redir;
    int lat, due, sel;
    imem_gnt    = ($urandom_range(99) < p_gnt);
    instr_ready = ($urandom_range(99) < p_ready);
    redir       = force_redir || ($urandom_range(99) < p_redir);
    redirect    = redir;
    sel = (redir_mode == 3) ? $urandom_range(2) : redir_mode;
    case (sel)
      1:       redirect_pc = 32'h0000_0100;
      2:       redirect_pc = 32'hFFFF_FFFD;
      default: redirect_pc = $urandom;
    endcase
    rv = (mq_addr.size() > 0) && (mq_due[0] <= t);
    imem_rvalid = rv;
    imem_rdata  = rv ? memw(mq_addr[0]) : $urandom;
    #1;
    e_req = run && (n_stale == 0) && (buf_pc.size() + infl.size() < DEPTH);
    byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = (buf_pc.size() == 0) && (n_stale == 0) && !redir && rv;
`endif
    if (buf_pc.size() > 0) begin
      e_v = 1'b1; e_i = buf_w[0]; e_pc = buf_pc[0];
    end else if (byp) begin
      e_v = 1'b1; e_i = memw(infl[0]); e_pc = infl[0];
    end else begin
      e_v = 1'b0; e_i = last_i; e_pc = last_pc;
    end
    check_val("imem_req",    {31'h0, imem_req},    {31'h0, e_req});
    check_val("imem_addr",   imem_addr,            m_fetch_pc);
    check_val("instr_valid", {31'h0, instr_valid}, {31'h0, e_v});
    check_val("Instr",       Instr,                e_i);
    check_val("instr_pc",    instr_pc,             e_pc);

    // advance the model by one clock
    grant = e_req && imem_gnt;
    pop   = !redir && instr_ready && (buf_pc.size() > 0);
    if (e_v) begin last_i = e_i; last_pc = e_pc; end
    if (pop) begin void'(buf_pc.pop_front()); void'(buf_w.pop_front()); end
    if (grant) begin
      infl.push_back(m_fetch_pc);
      lat = $urandom_range(lat_max, 1);
      due = t + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq_addr.push_back(m_fetch_pc);
      mq_due.push_back(due);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (rv) begin
      rsp_pc = infl.pop_front();
      void'(mq_addr.pop_front()); void'(mq_due.pop_front());
      if (n_stale > 0) n_stale--;
      else if (!redir && !(byp && instr_ready)) begin
        buf_pc.push_back(rsp_pc); buf_w.push_back(memw(rsp_pc));
      end
    end
    if (redir) begin
      buf_pc.delete(); buf_w.delete();
      n_stale = infl.size();
      m_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
    end
    run = 1'b1;
    t++;
  endtask

  task automatic run_phase(input int n, input int g, input int r, input int rd,
                           input int lat, input int mode);
    p_gnt = g; p_ready = r; p_redir = rd; lat_max = lat; redir_mode = mode;
    repeat (n) begin
      @(negedge clk);
      step();
    end
  endtask

  task automatic redirect_once(input int mode);
    redir_mode = mode; force_redir = 1'b1;
    @(negedge clk);
    step();
    force_redir = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    p_gnt = 100; p_ready = 100; p_redir = 0; lat_max = 1; redir_mode = 0;
    model_reset();
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    step();

    // streaming, then stall with a full queue, then drain in order
    run_phase(30, 100, 100, 0, 1, 0);
    run_phase(20, 100, 0,   0, 1, 0);
    run_phase(20, 100, 100, 0, 1, 0);

    // redirect to 0x100 with three requests in flight
    run_phase(6, 100, 100, 0, 3, 0);
    redirect_once(1);
    run_phase(20, 100, 100, 0, 3, 0);

    // redirect to an unaligned top-of-memory target, then wrap
    redirect_once(2);
    run_phase(12, 100, 100, 0, 2, 0);

    // reset while draining stale requests
    run_phase(2, 100, 0, 0, 3, 0);
    redirect_once(1);
    do_reset();
    run_phase(15, 100, 100, 0, 1, 0);

    // random traffic with occasional redirects and resets
    for (int k = 0; k < 8; k++) begin
      run_phase(300, $urandom_range(100, 30), $urandom_range(100, 20),
                $urandom_range(8), $urandom_range(4, 1), 3);
      if (k % 3 == 2) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
